// File: rtl/pp_accumulator_array.sv
// pp_accumulator_array
// Reduces the Booth partial products of every multiplier lane to a final
// product by serial accumulation (one partial product per cycle, all lanes in
// parallel). It then registers the per-lane products together with their
// signed dot-product sum.
//
// Handshake semantics (both sides): a transfer happens on a rising clk_i edge
// where valid and ready are both high. The producer holds valid and data
// stable until that edge. The consumer may raise or drop ready at any time,
// independent of valid. in_ready_o is high only in IDLE. out_valid_o stays
// high and prod_o/dot_o stay frozen from REDUCE until the output transfer.
module pp_accumulator_array #(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int SIZE_ARRAY = 8,
    localparam int P         = IN_SIZE_0 + IN_SIZE_1,
    localparam int NUM_PP    = (IN_SIZE_1 + 2) / 3,
    localparam int D         = P + $clog2(SIZE_ARRAY)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [P*NUM_PP*SIZE_ARRAY-1:0] pp_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [P*SIZE_ARRAY-1:0]      prod_o,
    output logic [D-1:0]                 dot_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [1:0]                   dbg_state_o
);

    localparam int NE = NUM_PP * SIZE_ARRAY;
    localparam int CW = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_REDUCE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]              r_state;
    logic [CW-1:0]           r_count;
    logic                    r_out_valid;
    logic [P-1:0]            r_pp  [NE];
    logic [P-1:0]            r_acc [SIZE_ARRAY];
    logic [P*SIZE_ARRAY-1:0] r_prod;
    logic [D-1:0]            r_dot;

    logic [P-1:0]            w_sel [SIZE_ARRAY];
    logic [D-1:0]            w_dot;
    logic                    w_accept;
    logic                    w_last;

    assign w_accept    = in_valid_i && (r_state == S_IDLE);
    assign w_last      = (r_count == CW'(NUM_PP - 1));

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = r_out_valid;
    assign prod_o      = r_prod;
    assign dot_o       = r_dot;
    assign dbg_state_o = r_state;

    // Pick each lane's partial product for the current accumulation step.
    always_comb begin
        for (int i = 0; i < SIZE_ARRAY; i++) begin
            w_sel[i] = '0;
            for (int k = 0; k < NUM_PP; k++) begin
                if (r_count == CW'(k)) begin
                    w_sel[i] = r_pp[i*NUM_PP + k];
                end
            end
        end
    end

    // Single-cycle adder tree: sign-extend every lane to D bits and sum.
    always_comb begin
        w_dot = '0;
        for (int i = 0; i < SIZE_ARRAY; i++) begin
            w_dot = w_dot + D'($signed(r_acc[i]));
        end
    end

    // Control FSM: state, step counter and output valid flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                default: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Capture the whole partial-product vector only on the accept edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < NE; j++) begin
                r_pp[j] <= '0;
            end
        end else if (w_accept) begin
            for (int j = 0; j < NE; j++) begin
                r_pp[j] <= pp_i[j*P +: P];
            end
        end
    end

    // Per-lane accumulators: cleared on accept, one add per ACCUM cycle (mod 2^P).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                r_acc[i] <= '0;
            end
        end else if (r_state == S_ACCUM) begin
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                r_acc[i] <= r_acc[i] + w_sel[i];
            end
        end
    end

    // Result registers: loaded in REDUCE, frozen through DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prod <= '0;
            r_dot  <= '0;
        end else if (r_state == S_REDUCE) begin
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                r_prod[i*P +: P] <= r_acc[i];
            end
            r_dot <= w_dot;
        end
    end

endmodule

// File: tb/tb_pp_accumulator_array.sv
// Bench for pp_accumulator_array: directed scenarios followed by randomized
// traffic with backpressure, scored against an arithmetic reference model.
module tb_pp_accumulator_array;

    localparam int IN_SIZE_0  = 4;
    localparam int IN_SIZE_1  = 8;
    localparam int SIZE_ARRAY = 8;
    localparam int P          = 12;
    localparam int NUM_PP     = 3;
    localparam int D          = 15;
    localparam int NE         = NUM_PP * SIZE_ARRAY;
    localparam int PW         = P * NE;
    localparam int OW         = P * SIZE_ARRAY;

    // ---------------- clock / reset / DUT ----------------
    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [PW-1:0] pp_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [OW-1:0] prod_o;
    logic [D-1:0]  dot_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [1:0]    dbg_state_o;

    always #5 clk_i = ~clk_i;

    pp_accumulator_array #(
        .IN_SIZE_0  (IN_SIZE_0),
        .IN_SIZE_1  (IN_SIZE_1),
        .SIZE_ARRAY (SIZE_ARRAY)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pp_i        (pp_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .prod_o      (prod_o),
        .dot_o       (dot_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic [OW-1:0] exp_prod_q[$];
    logic [D-1:0]  exp_dot_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each lane product is the two's-complement sum of its partial
    // products taken modulo 2^P; the dot product is the signed sum of lanes.
    function automatic void model(input logic [PW-1:0] pp,
                                  output logic [OW-1:0] prod,
                                  output logic [D-1:0] dot);
        int           s;
        int           d;
        logic [P-1:0] e;
        logic [P-1:0] lane;
        d    = 0;
        prod = '0;
        for (int i = 0; i < SIZE_ARRAY; i++) begin
            s = 0;
            for (int k = 0; k < NUM_PP; k++) begin
                e = pp[(i*NUM_PP + k)*P +: P];
                s = s + int'($signed(e));
            end
            lane = s[P-1:0];
            prod[i*P +: P] = lane;
            d = d + int'($signed(lane));
        end
        dot = d[D-1:0];
    endfunction

    task automatic push_expect(input logic [PW-1:0] pp);
        logic [OW-1:0] p;
        logic [D-1:0]  d;
        model(pp, p, d);
        exp_prod_q.push_back(p);
        exp_dot_q.push_back(d);
    endtask

    task automatic check_out();
        if (exp_prod_q.size() == 0) begin
            chk("unexpected_output", out_valid_o, 1'b0);
        end else begin
            chk("prod", prod_o, exp_prod_q.pop_front());
            chk("dot", dot_o, exp_dot_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: record transfers seen in this cycle, then advance.
    task automatic step();
        if (in_valid_i && in_ready_o) push_expect(pp_i);
        if (out_valid_o && out_ready_i) check_out();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid_o && n < 50) begin
            step();
            n++;
        end
        if (!out_valid_o) chk({tag, "_out_valid_timeout"}, out_valid_o, 1'b1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready_o && n < 50) begin
            step();
            n++;
        end
        if (!in_ready_o) chk({tag, "_in_ready_timeout"}, in_ready_o, 1'b1);
    endtask

    function automatic logic [PW-1:0] fill_all(input logic [P-1:0] a, input logic [P-1:0] b,
                                              input logic [P-1:0] c);
        logic [PW-1:0] v;
        for (int i = 0; i < SIZE_ARRAY; i++) begin
            v[(i*NUM_PP + 0)*P +: P] = a;
            v[(i*NUM_PP + 1)*P +: P] = b;
            v[(i*NUM_PP + 2)*P +: P] = c;
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] rand_pp();
        logic [PW-1:0] v;
        for (int j = 0; j < NE; j++) v[j*P +: P] = P'($urandom);
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [PW-1:0] v;
        int            c0;
        int            sent;
        int            guard;
        logic          acc;

        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        pp_i        = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_prod", prod_o, '0);
        chk("rst_dot", dot_o, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: identical lanes, latency and throughput
        out_ready_i = 1'b1;
        pp_i        = fill_all(12'h003, 12'h005, 12'hFFE);
        in_valid_i  = 1'b1;
        c0          = cyc;
        chk("t1_in_ready", in_ready_o, 1'b1);
        step();
        in_valid_i = 1'b0;
        chk("t1_busy_in_ready", in_ready_o, 1'b0);
        wait_valid("t1");
        chk("t1_latency", cyc - c0, 5);
        chk("t1_prod_const", prod_o, {8{12'h006}});
        chk("t1_dot_const", dot_o, 15'd48);
        step();
        chk("t1_in_ready_c6", in_ready_o, 1'b1);
        chk("t1_out_valid_c6", out_valid_o, 1'b0);

        // 2: wrap of a single lane to the most negative product
        v = '0;
        v[0 +: P]     = 12'h7FF;
        v[P +: P]     = 12'h001;
        pp_i          = v;
        in_valid_i    = 1'b1;
        step();
        in_valid_i = 1'b0;
        wait_valid("t2");
        chk("t2_prod0", prod_o[P-1:0], 12'h800);
        chk("t2_dot", dot_o, 15'h7800);
        step();

        // 3: backpressure holds the result; pulses on in_valid_i are ignored
        out_ready_i = 1'b0;
        pp_i        = rand_pp();
        in_valid_i  = 1'b1;
        step();
        in_valid_i = 1'b0;
        wait_valid("t3");
        for (int j = 0; j < 10; j++) begin
            chk("t3_hold_prod", prod_o, exp_prod_q[0]);
            chk("t3_hold_dot", dot_o, exp_dot_q[0]);
            chk("t3_hold_valid", out_valid_o, 1'b1);
            chk("t3_in_ready_low", in_ready_o, 1'b0);
            in_valid_i = (j % 2 == 0);
            pp_i       = rand_pp();
            step();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        chk("t3_release_in_ready", in_ready_o, 1'b1);
        chk("t3_release_valid", out_valid_o, 1'b0);

        // 4: in_valid_i held high across two vectors
        pp_i       = rand_pp();
        in_valid_i = 1'b1;
        c0         = cyc;
        step();
        pp_i = rand_pp();
        wait_ready("t4");
        chk("t4_second_accept_cycle", cyc - c0, 6);
        step();
        in_valid_i = 1'b0;
        wait_valid("t4");
        step();
        chk("t4_queue_drained", exp_prod_q.size(), 0);

        // 5: reset during ACCUM cycle 2 drops the in-flight vector
        pp_i       = rand_pp();
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        rst_ni = 1'b0;
        #1;
        chk("t5_rst_out_valid", out_valid_o, 1'b0);
        chk("t5_rst_prod", prod_o, '0);
        chk("t5_rst_dot", dot_o, '0);
        chk("t5_rst_in_ready", in_ready_o, 1'b1);
        void'(exp_prod_q.pop_back());
        void'(exp_dot_q.pop_back());
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t5_in_ready_after", in_ready_o, 1'b1);

        // 6: lane i = {i, -i, i}
        for (int i = 0; i < SIZE_ARRAY; i++) begin
            v[(i*NUM_PP + 0)*P +: P] = P'(i);
            v[(i*NUM_PP + 1)*P +: P] = P'(-i);
            v[(i*NUM_PP + 2)*P +: P] = P'(i);
        end
        pp_i       = v;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        wait_valid("t6");
        for (int i = 0; i < SIZE_ARRAY; i++) chk("t6_prod_lane", prod_o[i*P +: P], P'(i));
        chk("t6_dot", dot_o, 15'd28);
        step();

        // random traffic with random backpressure
        sent  = 0;
        guard = 0;
        while ((sent < 30 || exp_prod_q.size() != 0 || out_valid_o) && guard < 3000) begin
            if (!in_valid_i && sent < 30 && $urandom_range(0, 1) == 1) begin
                pp_i       = rand_pp();
                in_valid_i = 1'b1;
            end
            out_ready_i = ($urandom_range(0, 3) != 0);
            acc = in_valid_i && in_ready_o;
            step();
            if (acc) begin
                in_valid_i = 1'b0;
                sent++;
            end
            guard++;
        end
        if (guard >= 3000) chk("random_timeout", sent, 30);
        chk("scoreboard_empty", exp_prod_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
